mem_request_queue: RTL and testbench
====================================

Name: mem_request_queue

Overview:
- In-order request buffer that sits directly upstream of the core's block-RAM data memory and drives its read/write ports.
- Accepts load/store requests from the core over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one memory operation per cycle.
- Registers read data into a response slot that has its own valid/ready handshake, so a stalled consumer never loses data.

Parameters:
- CORE, 0, core index used in report output
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 8, word address width; must match the downstream memory
- DEPTH, 4, request FIFO entries; power of two, ≥2

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  queue can accept a request
- req_write  in  1  1 = store, 0 = load
- req_address  in  ADDR_WIDTH  word address
- req_data  in  DATA_WIDTH  store data; ignored for loads
- resp_valid  out  1  load response present
- resp_ready  in  1  consumer takes response
- resp_address  out  ADDR_WIDTH  address of the returned load
- resp_data  out  DATA_WIDTH  load data
- readEnable  out  1  to memory
- readAddress  out  ADDR_WIDTH  to memory
- readData  in  DATA_WIDTH  from memory; combinational, same-cycle read
- writeEnable  out  1  to memory
- writeAddress  out  ADDR_WIDTH  to memory
- writeData  out  DATA_WIDTH  to memory
- report  in  1  print state on the current clock edge

Behaviour:
- **Reset.** reset=1 clears:
  - wr/rd pointers and count, so the queue is empty;
  - resp_valid=0, resp_data=0, resp_address=0;
  - readEnable, writeEnable, readAddress, writeAddress, writeData are all 0 combinationally while reset=1.
- **Reset mid-operation.** All queued entries are discarded, no memory write occurs in the reset cycle, and a held response is dropped.
- **Push.** A push happens when req_valid & req_ready. It stores {write, address, data} at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
- **req_ready.** req_ready = !reset & (count != DEPTH). There is no push-when-full even if a pop occurs in the same cycle.
- **Issue.** Each cycle the head entry, if any, is examined.
  - Head is a store: writeEnable=1, writeAddress/writeData taken from the head, pop at the edge. A store never waits on the response slot.
  - Head is a load: it issues only if slot_free = !resp_valid | resp_ready. Then readEnable=1, readAddress=head address, and at the edge readData→resp_data, head address→resp_address, resp_valid=1, pop.
  - Head is a load and slot_free=0: no memory enable is asserted and the head stays.
- **Response slot.** Pop of the slot happens on resp_valid & resp_ready. If a new load issues in the same cycle, resp_valid stays 1 with the new data; otherwise resp_valid goes to 0. resp_data holds its value while resp_valid=1 and resp_ready=0.
- **Counting.** A simultaneous push and pop leaves count unchanged. Pointers are clog2(DEPTH) bits and wrap naturally; count is clog2(DEPTH)+1 bits.
- **Latency.** A load accepted at edge N into an empty queue is issued in cycle N+1, and resp_valid=1 after edge N+1. Throughput is 1 op/cycle while the consumer keeps resp_ready=1.
- **Ordering.** Strict program order. A load after a store to the same address returns the stored value, because the store commits at an earlier edge.
- **Enables.** readEnable and writeEnable are never both 1 in the same cycle.
- **report.** On each clock edge with report=1, prints CORE, a cycle counter, count, head entry, and response slot contents. The cycle counter is cleared by reset.

Optional Feature:
- Macro: MEM_QUEUE_BYPASS_EN
- Defined: when count==0, req_valid=1 and (for a load) slot_free, the incoming request is issued to memory combinationally in the same cycle and is not written into the FIFO. Load response is valid after the acceptance edge (1-cycle latency); a store commits at the acceptance edge.
- Undefined: every request passes through the FIFO, with a 2-cycle minimum load latency as above.

Test Plan:
1. **Reset.** reset high for 2 cycles with req_valid=1 → req_ready=0, resp_valid=0, no memory enables; afterwards the queue is empty and req_ready=1.
2. **Store then load.** Store addr 0x10 data 0xDEADBEEF, then load 0x10, resp_ready=1 → writeEnable pulse with addr 0x10, then resp_valid=1, resp_data=0xDEADBEEF, resp_address=0x10, 2 cycles after the load is accepted (1 with MEM_QUEUE_BYPASS_EN).
3. **Full.** resp_ready=0; push 1 load then DEPTH further loads (addrs 0x00–0x04) → after the 1st load issues, count reaches 4 and req_ready=0. Raising resp_ready drains in order: addrs 0x00,0x01,0x02,0x03,0x04 with no loss.
4. **Back-pressure.** resp_valid held with resp_ready=0 for 5 cycles, head is a load → readEnable=0 throughout and resp_data stable. With a store at the head instead, the store still commits.
5. **Wrap-around.** 3×DEPTH alternating push/pop with resp_ready=1 → pointers wrap, responses match the sequence 0x00..0x0B, count never exceeds 2.
6. **Reset mid-operation.** 3 queued stores, assert reset for 1 cycle → none of the remaining stores reaches memory, count=0 next cycle, and a following load of a targeted address returns the old memory contents.

Source files
------------

// File: rtl/mem_request_queue.sv
// ============================================================================
// Module   : mem_request_queue
// Purpose  : In-order load/store request FIFO in front of a same-cycle-read
//            block RAM, with a registered load-response slot.
// Options  : define MEM_QUEUE_BYPASS_EN to issue into an empty queue directly
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_request_queue #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_address,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  readEnable,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic                  report
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic                  fifo_write_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q  [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [ADDR_WIDTH-1:0] resp_address_q, resp_address_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [31:0]           cycle_q, cycle_d;

  logic                  head_valid;
  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  slot_free;
  logic                  push;
  logic                  pop;

  always_comb begin
    head_valid   = (count_q != '0);
    head_write   = fifo_write_q[rd_ptr_q];
    head_addr    = fifo_addr_q[rd_ptr_q];
    head_data    = fifo_data_q[rd_ptr_q];
    slot_free    = !resp_valid_q || resp_ready;
    req_ready    = !reset && (count_q != FULL_COUNT);
    push         = req_valid && req_ready;
    pop          = 1'b0;
    readEnable   = 1'b0;
    readAddress  = '0;
    writeEnable  = 1'b0;
    writeAddress = '0;
    writeData    = '0;

    // Stores retire regardless of the response slot; loads need a free slot.
    if (!reset && head_valid) begin
      if (head_write) begin
        writeEnable  = 1'b1;
        writeAddress = head_addr;
        writeData    = head_data;
        pop          = 1'b1;
      end else if (slot_free) begin
        readEnable  = 1'b1;
        readAddress = head_addr;
        pop         = 1'b1;
      end
    end
`ifdef MEM_QUEUE_BYPASS_EN
    // Empty queue: send the incoming request straight to memory instead.
    else if (push && (req_write || slot_free)) begin
      push = 1'b0;
      if (req_write) begin
        writeEnable  = 1'b1;
        writeAddress = req_address;
        writeData    = req_data;
      end else begin
        readEnable  = 1'b1;
        readAddress = req_address;
      end
    end
`endif

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    resp_valid_d   = resp_valid_q;
    resp_address_d = resp_address_q;
    resp_data_d    = resp_data_q;
    if (readEnable) begin
      resp_valid_d   = 1'b1;
      resp_address_d = readAddress;
      resp_data_d    = readData;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end

    cycle_d = cycle_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_address_q <= '0;
      resp_data_q    <= '0;
      cycle_q        <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      resp_valid_q   <= resp_valid_d;
      resp_address_q <= resp_address_d;
      resp_data_q    <= resp_data_d;
      cycle_q        <= cycle_d;
    end
  end

  // Entry storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= req_write;
      fifo_addr_q[wr_ptr_q]  <= req_address;
      fifo_data_q[wr_ptr_q]  <= req_data;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_address = resp_address_q;
  assign resp_data    = resp_data_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report) begin
      $display("core %0d cycle %0d count %0d head(v=%0b w=%0b a=%h d=%h) resp(v=%0b a=%h d=%h)",
               CORE, cycle_q, count_q, head_valid, head_write, head_addr, head_data,
               resp_valid_q, resp_address_q, resp_data_q);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_request_queue.sv
// Directed self-checking bench for mem_request_queue with a behavioural
// same-cycle-read memory attached to its read/write ports.
`default_nettype none

module tb_mem_request_queue;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef MEM_QUEUE_BYPASS_EN
  localparam int LOAD_LAT = 1;
`else
  localparam int LOAD_LAT = 2;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [AW-1:0] resp_address;
  logic [DW-1:0] resp_data;
  logic          readEnable, writeEnable;
  logic [AW-1:0] readAddress, writeAddress;
  logic [DW-1:0] readData, writeData;
  logic          report;

  logic [DW-1:0] mem [256];
  logic          mem_init;
  int            wr_cnt;
  int            checks   = 0;
  int            failures = 0;

  mem_request_queue #(.CORE(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_address(resp_address), .resp_data(resp_data),
    .readEnable(readEnable), .readAddress(readAddress), .readData(readData),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .report(report)
  );

  always #5 clock = ~clock;

  // Memory model: every word initialised to A000_0000 | address.
  assign readData = mem[readAddress];
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      wr_cnt <= 0;
    end else if (writeEnable) begin
      mem[writeAddress] <= writeData;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_address = '0;
    req_data    = '0;
  endtask

  task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = a;
    req_data    = d;
  endtask

  task automatic test_reset;
    mem_init = 1'b1; reset = 1'b1; report = 1'b0; resp_ready = 1'b1;
    drive(1'b1, 8'h55, 32'h1);
    for (int c = 0; c < 2; c++) begin
      tick;
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b exp 0", req_ready); end
      checks++; if (writeEnable !== 1'b0 || readEnable !== 1'b0) begin failures++; $display("FAIL reset_enables: got we=%b re=%b exp 0/0", writeEnable, readEnable); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); end
    end
    reset = 1'b0; mem_init = 1'b0; report = 1'b1;
    idle;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready: got %b exp 1", req_ready); end
    checks++; if (resp_data !== 32'h0 || resp_address !== 8'h0) begin failures++; $display("FAIL post_reset_resp: got a=%h d=%h exp 0/0", resp_address, resp_data); end
    checks++; if (writeEnable !== 1'b0 || readEnable !== 1'b0) begin failures++; $display("FAIL post_reset_enables: got we=%b re=%b exp 0/0", writeEnable, readEnable); end
    tick;
    report = 1'b0;
  endtask

  task automatic test_store_load;
    int w0;
    int seen;
    w0 = wr_cnt; resp_ready = 1'b1;
    drive(1'b1, 8'h10, 32'hDEADBEEF);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL sl_store_ready: got %b exp 1", req_ready); end
    tick;
    drive(1'b0, 8'h10, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL sl_load_ready: got %b exp 1", req_ready); end
    tick;
    idle;
    seen = 0;
    for (int k = 1; k <= 4; k++) begin
      if (resp_valid === 1'b1 && seen == 0) begin
        seen = k;
        checks++; if (resp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_resp_data: got %h exp deadbeef", resp_data); end
        checks++; if (resp_address !== 8'h10) begin failures++; $display("FAIL sl_resp_addr: got %h exp 10", resp_address); end
      end
      tick;
    end
    checks++; if (seen != LOAD_LAT) begin failures++; $display("FAIL sl_latency: got %0d exp %0d", seen, LOAD_LAT); end
    checks++; if (wr_cnt != w0 + 1) begin failures++; $display("FAIL sl_write_count: got %0d exp %0d", wr_cnt - w0, 1); end
    checks++; if (mem[8'h10] !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_mem_word: got %h exp deadbeef", mem[8'h10]); end
  endtask

  task automatic test_full;
    int got;
    resp_ready = 1'b0;
    for (int a = 0; a < 5; a++) begin
      drive(1'b0, AW'(a), 32'h0);
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL full_accept_%0d: got %b exp 1", a, req_ready); end
      tick;
    end
    drive(1'b0, 8'h05, 32'h0);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_req_ready: got %b exp 0", req_ready); end
    checks++; if (readEnable !== 1'b0) begin failures++; $display("FAIL full_read_blocked: got %b exp 0", readEnable); end
    checks++; if (resp_valid !== 1'b1 || resp_address !== 8'h00) begin failures++; $display("FAIL full_slot: got v=%b a=%h exp 1/00", resp_valid, resp_address); end
    tick;
    idle;
    resp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      if (resp_valid === 1'b1) begin
        checks++; if (resp_address !== AW'(got) || resp_data !== (32'hA000_0000 | 32'(got))) begin
          failures++; $display("FAIL full_drain_%0d: got a=%h d=%h exp a=%h d=%h", got, resp_address, resp_data, AW'(got), 32'hA000_0000 | 32'(got));
        end
        got++;
      end
      tick;
    end
    checks++; if (got != 5) begin failures++; $display("FAIL full_drain_count: got %0d exp 5", got); end
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL full_empty_after: got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_back_pressure;
    int w0;
    resp_ready = 1'b0;
    drive(1'b0, 8'h20, 32'h0); tick;
    drive(1'b0, 8'h21, 32'h0); tick;
    idle;
    for (int c = 0; c < 5; c++) begin
      checks++; if (readEnable !== 1'b0 || resp_valid !== 1'b1 || resp_data !== 32'hA000_0020) begin
        failures++; $display("FAIL bp_hold_%0d: got re=%b v=%b d=%h exp 0/1/a0000020", c, readEnable, resp_valid, resp_data);
      end
      tick;
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (readEnable !== 1'b1 || readAddress !== 8'h21) begin failures++; $display("FAIL bp_release_issue: got re=%b a=%h exp 1/21", readEnable, readAddress); end
    tick;
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hA000_0021 || resp_address !== 8'h21) begin
      failures++; $display("FAIL bp_second_resp: got v=%b a=%h d=%h exp 1/21/a0000021", resp_valid, resp_address, resp_data);
    end
    w0 = wr_cnt;
    drive(1'b1, 8'h22, 32'h1234_5678);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_store_ready: got %b exp 1", req_ready); end
    tick;
    idle;
    tick;
    tick;
    checks++; if (wr_cnt != w0 + 1 || mem[8'h22] !== 32'h1234_5678) begin failures++; $display("FAIL bp_store_commit: got n=%0d d=%h exp 1/12345678", wr_cnt - w0, mem[8'h22]); end
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hA000_0021) begin failures++; $display("FAIL bp_store_slot_kept: got v=%b d=%h exp 1/a0000021", resp_valid, resp_data); end
    resp_ready = 1'b1;
    tick;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_slot_popped: got %b exp 0", resp_valid); end
  endtask

  task automatic test_wrap;
    int pushed;
    int got;
    resp_ready = 1'b1;
    pushed = 0;
    got    = 0;
    for (int cyc = 0; cyc < 40 && got < 3 * DEPTH; cyc++) begin
      if (pushed < 3 * DEPTH) drive(1'b0, AW'(pushed), 32'h0);
      else idle;
      #1;
      if (req_valid === 1'b1) begin
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wrap_ready_%0d: got %b exp 1", pushed, req_ready); end
        if (req_ready === 1'b1) pushed++;
      end
      if (resp_valid === 1'b1) begin
        checks++; if (resp_address !== AW'(got) || resp_data !== (32'hA000_0000 | 32'(got))) begin
          failures++; $display("FAIL wrap_resp_%0d: got a=%h d=%h exp a=%h d=%h", got, resp_address, resp_data, AW'(got), 32'hA000_0000 | 32'(got));
        end
        got++;
      end
      tick;
    end
    idle;
    checks++; if (got != 3 * DEPTH) begin failures++; $display("FAIL wrap_count: got %0d exp %0d", got, 3 * DEPTH); end
  endtask

  task automatic test_reset_mid;
    int w0;
    int seen;
    w0 = wr_cnt;
    resp_ready = 1'b0;
    drive(1'b0, 8'h40, 32'h0);          tick;
    drive(1'b0, 8'h41, 32'h0);          tick;
    drive(1'b1, 8'h30, 32'h1111_1111);  tick;
    drive(1'b1, 8'h31, 32'h2222_2222);  tick;
    drive(1'b1, 8'h32, 32'h3333_3333);  tick;
    idle;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rm_full_before: got %b exp 0", req_ready); end
    reset = 1'b1;
    #1;
    checks++; if (writeEnable !== 1'b0 || readEnable !== 1'b0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL rm_in_reset: got we=%b re=%b rdy=%b exp 0/0/0", writeEnable, readEnable, req_ready);
    end
    tick;
    reset = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin failures++; $display("FAIL rm_slot_dropped: got v=%b d=%h exp 0/0", resp_valid, resp_data); end
    checks++; if (req_ready !== 1'b1 || writeEnable !== 1'b0) begin failures++; $display("FAIL rm_empty: got rdy=%b we=%b exp 1/0", req_ready, writeEnable); end
    tick; tick; tick;
    checks++; if (wr_cnt != w0) begin failures++; $display("FAIL rm_no_writes: got %0d exp 0", wr_cnt - w0); end
    checks++; if (mem[8'h30] !== 32'hA000_0030 || mem[8'h32] !== 32'hA000_0032) begin failures++; $display("FAIL rm_mem_old: got %h %h exp a0000030 a0000032", mem[8'h30], mem[8'h32]); end
    resp_ready = 1'b1;
    drive(1'b0, 8'h31, 32'h0);
    tick;
    idle;
    seen = 0;
    for (int k = 1; k <= 4; k++) begin
      if (resp_valid === 1'b1 && seen == 0) begin
        seen = k;
        checks++; if (resp_data !== 32'hA000_0031) begin failures++; $display("FAIL rm_load_old: got %h exp a0000031", resp_data); end
      end
      tick;
    end
    checks++; if (seen != LOAD_LAT) begin failures++; $display("FAIL rm_load_latency: got %0d exp %0d", seen, LOAD_LAT); end
  endtask

  initial begin
    idle;
    test_reset;
    test_store_load;
    test_full;
    test_back_pressure;
    test_wrap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
